cpu_halt_monitor: RTL and testbench

Synthesizable run-control monitor for the multicycle MIPS core. It observes the core's current instruction and its controller state, and counts cycles and fetch events. It raises a halt on any of NUM_BP programmable masked instruction breakpoints, each with its own hit count, or on a fetch-starvation timeout. Benches and the FPGA top use it in place of ad-hoc stop conditions; a halt holds until an explicit resume.

---
 rtl/cpu_halt_monitor.sv | 188 ++++++++++++++++++
 tb/tb_cpu_halt_monitor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_halt_monitor.sv
// cpu_halt_monitor: run-control monitor for the multicycle MIPS core.
// Watches the current instruction and controller state, counts RUN cycles and
// fetch events, and halts on a masked instruction breakpoint (per-slot hit
// count) or on a fetch-starvation timeout. A halt holds until resume_i.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   instruction_i        instruction currently held by the core
//   state_i              current controller FSM state
//   bp_wr_*_i            breakpoint slot write (idx, value, care mask, target)
//   resume_i             single-cycle pulse that leaves HALTED
//   halted_o             registered halt flag
//   halt_cause_o         00 none, 01 breakpoint, 10 timeout
//   halt_bp_idx_o        slot that caused a breakpoint halt
//   cycle_count_o        RUN cycles since reset (saturating)
//   instr_count_o        fetch events in RUN since reset (saturating)
module cpu_halt_monitor #(
    parameter int unsigned NUM_BP      = 4,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned FETCH_STATE = 0,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 1000,
    localparam int unsigned IDX_W      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INSTR_W-1:0] instruction_i,
    input  logic [STATE_W-1:0] state_i,
    input  logic               bp_wr_en_i,
    input  logic [IDX_W-1:0]   bp_wr_idx_i,
    input  logic [INSTR_W-1:0] bp_wr_value_i,
    input  logic [INSTR_W-1:0] bp_wr_mask_i,
    input  logic [7:0]         bp_wr_target_i,
    input  logic               resume_i,
    output logic               halted_o,
    output logic [1:0]         halt_cause_o,
    output logic [IDX_W-1:0]   halt_bp_idx_o,
    output logic [CNT_W-1:0]   cycle_count_o,
    output logic [CNT_W-1:0]   instr_count_o
);

    localparam int unsigned TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseBp   = 2'b01;
    localparam logic [1:0] CauseTmo  = 2'b10;

    typedef enum logic [0:0] {StRun, StHalted} fsm_e;

    fsm_e               fsm_q;
    logic               halted_q;
    logic [1:0]         cause_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   instr_q;
    logic [TC_W-1:0]    tcnt_q;

    logic [INSTR_W-1:0] value_q  [NUM_BP];
    logic [INSTR_W-1:0] mask_q   [NUM_BP];
    logic [7:0]         target_q [NUM_BP];
    logic [7:0]         hit_q    [NUM_BP];
    logic [7:0]         hit_d    [NUM_BP];

    logic               run;
    logic               fetch;
    logic               resume_go;
    logic               timeout_hit;
    logic               bp_fire;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_BP-1:0]  wr_sel;
    logic [NUM_BP-1:0]  match;
    logic [NUM_BP-1:0]  fire;

    assign run       = (fsm_q == StRun);
    assign fetch     = run && (state_i == STATE_W'(FETCH_STATE));
    assign resume_go = !run && resume_i;
    assign timeout_hit = (TIMEOUT != 0) && run && !fetch &&
                         (tcnt_q == TC_W'(TIMEOUT - 1));

    // A slot being written this cycle neither matches nor counts.
    // Out-of-range write indices select no slot at all.
    always_comb begin
        for (int k = 0; k < NUM_BP; k++) begin
            wr_sel[k] = bp_wr_en_i && (bp_wr_idx_i == IDX_W'(k));
            match[k]  = fetch && (target_q[k] != 8'd0) && !wr_sel[k] &&
                        (((instruction_i ^ value_q[k]) & mask_q[k]) == '0);
            fire[k]   = match[k] &&
                        (({1'b0, hit_q[k]} + 9'd1) >= {1'b0, target_q[k]});
        end
    end

    // Lowest firing index wins: scan downward so the last assignment is lowest.
    always_comb begin
        bp_fire = 1'b0;
        win_idx = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (fire[k]) begin
                bp_fire = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_BP; k++) begin
            hit_d[k] = hit_q[k];
            if (wr_sel[k]) begin
                hit_d[k] = 8'd0;
            end else if (resume_go && (cause_q == CauseBp) && (idx_q == IDX_W'(k))) begin
                hit_d[k] = 8'd0;
            end else if (match[k] && (hit_q[k] != 8'hff)) begin
                hit_d[k] = hit_q[k] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_BP; k++) begin
                value_q[k]  <= '0;
                mask_q[k]   <= '0;
                target_q[k] <= 8'd0;
                hit_q[k]    <= 8'd0;
            end
        end else begin
            for (int k = 0; k < NUM_BP; k++) begin
                if (wr_sel[k]) begin
                    value_q[k]  <= bp_wr_value_i;
                    mask_q[k]   <= bp_wr_mask_i;
                    target_q[k] <= bp_wr_target_i;
                end
                hit_q[k] <= hit_d[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q    <= StRun;
            halted_q <= 1'b0;
            cause_q  <= CauseNone;
            idx_q    <= '0;
            cycle_q  <= '0;
            instr_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            unique case (fsm_q)
                StRun: begin
                    if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
                    if (fetch && (instr_q != '1)) instr_q <= instr_q + 1'b1;
                    if (fetch) begin
                        tcnt_q <= '0;
                    end else if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                    // Breakpoint takes precedence over a same-cycle timeout.
                    if (bp_fire) begin
                        fsm_q    <= StHalted;
                        halted_q <= 1'b1;
                        cause_q  <= CauseBp;
                        idx_q    <= win_idx;
                    end else if (timeout_hit) begin
                        fsm_q    <= StHalted;
                        halted_q <= 1'b1;
                        cause_q  <= CauseTmo;
                        idx_q    <= '0;
                    end
                end
                StHalted: begin
                    if (resume_i) begin
                        fsm_q    <= StRun;
                        halted_q <= 1'b0;
                        cause_q  <= CauseNone;
                        idx_q    <= '0;
                        tcnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign halted_o      = halted_q;
    assign halt_cause_o  = cause_q;
    assign halt_bp_idx_o = idx_q;
    assign cycle_count_o = cycle_q;
    assign instr_count_o = instr_q;

endmodule

// File: tb/tb_cpu_halt_monitor.sv
// Self-checking bench for cpu_halt_monitor: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model.
module tb_cpu_halt_monitor;

    localparam int NB  = 4;
    localparam int TMO = 1000;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  st;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [31:0] wr_value;
    logic [31:0] wr_mask;
    logic [7:0]  wr_target;
    logic        resume;
    logic        halted;
    logic [1:0]  cause;
    logic [1:0]  bp_idx;
    logic [31:0] cyc_cnt;
    logic [31:0] ins_cnt;

    cpu_halt_monitor #(
        .NUM_BP     (NB),
        .INSTR_W    (32),
        .STATE_W    (4),
        .FETCH_STATE(0),
        .CNT_W      (32),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instruction_i (instr),
        .state_i       (st),
        .bp_wr_en_i    (wr_en),
        .bp_wr_idx_i   (wr_idx),
        .bp_wr_value_i (wr_value),
        .bp_wr_mask_i  (wr_mask),
        .bp_wr_target_i(wr_target),
        .resume_i      (resume),
        .halted_o      (halted),
        .halt_cause_o  (cause),
        .halt_bp_idx_o (bp_idx),
        .cycle_count_o (cyc_cnt),
        .instr_count_o (ins_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    int          m_val  [NB];
    int          m_mask [NB];
    int          m_tgt  [NB];
    int          m_hit  [NB];
    bit          m_halted;
    int          m_cause;
    int          m_idx;
    longint      m_cycles;
    longint      m_instrs;
    int          m_idle;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_val[k] = 0; m_mask[k] = 0; m_tgt[k] = 0; m_hit[k] = 0;
        end
        m_halted = 0; m_cause = 0; m_idx = 0;
        m_cycles = 0; m_instrs = 0; m_idle = 0;
    endtask

    // One clock edge worth of the rules, using the inputs present at that edge.
    task automatic model_edge();
        bit fetch;
        int win;
        if (!m_halted) begin
            fetch = (st == 4'd0);
            win = -1;
            for (int k = 0; k < NB; k++) begin
                if (wr_en && wr_idx == k) continue;
                if (m_tgt[k] != 0 && fetch && ((instr ^ m_val[k]) & m_mask[k]) == 0) begin
                    if (m_hit[k] + 1 >= m_tgt[k] && win < 0) win = k;
                    if (m_hit[k] < 255) m_hit[k]++;
                end
            end
            m_cycles++;
            if (fetch) m_instrs++;
            if (win >= 0) begin
                m_halted = 1; m_cause = 1; m_idx = win;
            end else if (!fetch && m_idle == TMO - 1) begin
                m_halted = 1; m_cause = 2; m_idx = 0;
            end
            m_idle = fetch ? 0 : m_idle + 1;
        end else if (resume) begin
            if (m_cause == 1) m_hit[m_idx] = 0;
            m_halted = 0; m_cause = 0; m_idx = 0; m_idle = 0;
        end
        if (wr_en && wr_idx < NB) begin
            m_val[wr_idx]  = wr_value;
            m_mask[wr_idx] = wr_mask;
            m_tgt[wr_idx]  = wr_target;
            m_hit[wr_idx]  = 0;
        end
    endtask

    task automatic compare_all();
        check_eq("halted", halted, m_halted);
        check_eq("cause", cause, m_cause);
        check_eq("bp_idx", bp_idx, m_idx);
        check_eq("cycle_count", cyc_cnt, m_cycles);
        check_eq("instr_count", ins_cnt, m_instrs);
        for (int k = 0; k < NB; k++) check_eq($sformatf("hit%0d", k), dut.hit_q[k], m_hit[k]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic [3:0] s, input logic [31:0] ins);
        st = s;
        instr = ins;
    endtask

    task automatic write_slot(input int k, input logic [31:0] v, input logic [31:0] m,
                              input int t);
        wr_en = 1'b1; wr_idx = 2'(k); wr_value = v; wr_mask = m; wr_target = 8'(t);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        step();
        resume = 1'b0;
    endtask

    logic [31:0] pool [4];

    initial begin
        pool[0] = 32'hac020054; pool[1] = 32'h8c010000;
        pool[2] = 32'hac000010; pool[3] = 32'h00001234;
        rst_n = 1'b0; instr = '0; st = 4'd3; wr_en = 1'b0; wr_idx = '0;
        wr_value = '0; wr_mask = '0; wr_target = '0; resume = 1'b0;
        model_reset();
        #12;
        check_eq("reset_halted", halted, 0);
        check_eq("reset_cycles", cyc_cnt, 0);
        rst_n = 1'b1;

        // Exact-match breakpoint on the sixth fetch.
        write_slot(0, 32'hac020054, 32'hffffffff, 1);
        for (int i = 0; i < 5; i++) begin
            drive(4'd0, 32'h00000000);
            step();
        end
        drive(4'd0, 32'hac020054);
        step();
        check_eq("t1_halted", halted, 1);
        check_eq("t1_cause", cause, 1);
        check_eq("t1_idx", bp_idx, 0);
        check_eq("t1_instrs", ins_cnt, 6);
        drive(4'd0, 32'h0);
        steps(20);
        check_eq("t1_frozen", ins_cnt, 6);
        drive(4'd3, 32'h0);
        pulse_resume();
        write_slot(0, 32'h0, 32'h0, 0);

        // Masked slot with target 3: halt only after the third sw.
        write_slot(2, 32'hac000000, 32'hfc000000, 3);
        for (int i = 0; i < 3; i++) begin
            drive(4'd0, 32'hac000000 | 32'(i));
            step();
            if (i < 2) begin
                check_eq("t2_nohalt", halted, 0);
                drive(4'd0, 32'h8c000000);
                step();
            end
        end
        check_eq("t2_halted", halted, 1);
        check_eq("t2_idx", bp_idx, 2);
        drive(4'd3, 32'h0);
        pulse_resume();
        drive(4'd0, 32'hac000100);
        steps(2);
        drive(4'd3, 32'h0);
        step();
        check_eq("t2_resumed_nohalt", halted, 0);
        write_slot(2, 32'h0, 32'h0, 0);

        // Two slots firing together: lowest index wins.
        write_slot(1, 32'h8c010000, 32'hffffffff, 1);
        write_slot(3, 32'h8c010000, 32'hffffffff, 1);
        drive(4'd0, 32'h8c010000);
        step();
        check_eq("t3_idx", bp_idx, 1);
        check_eq("t3_hit3", dut.hit_q[3], 1);
        drive(4'd3, 32'h0);
        pulse_resume();
        check_eq("t3_hit3_kept", dut.hit_q[3], 1);
        check_eq("t3_hit1_clr", dut.hit_q[1], 0);
        write_slot(1, 32'h0, 32'h0, 0);
        write_slot(3, 32'h0, 32'h0, 0);

        // Timeout after exactly TMO fetch-less RUN cycles.
        drive(4'd0, 32'h0);
        step();
        drive(4'd3, 32'h0);
        steps(TMO - 1);
        check_eq("t4_not_yet", halted, 0);
        step();
        check_eq("t4_halted", halted, 1);
        check_eq("t4_cause", cause, 2);
        pulse_resume();
        drive(4'd0, 32'h0);
        step();
        drive(4'd3, 32'h0);
        steps(TMO - 1);
        drive(4'd0, 32'h0);
        step();
        drive(4'd3, 32'h0);
        steps(3);
        check_eq("t4_fetch_saves", halted, 0);

        // Write colliding with its own match, then resume while running.
        wr_en = 1'b1; wr_idx = 2'd0; wr_value = 32'h00001234;
        wr_mask = 32'hffffffff; wr_target = 8'd1;
        drive(4'd0, 32'h00001234);
        step();
        wr_en = 1'b0;
        check_eq("t5_no_halt", halted, 0);
        check_eq("t5_hit0", dut.hit_q[0], 0);
        drive(4'd3, 32'h0);
        pulse_resume();
        check_eq("t5_resume_run", halted, 0);
        drive(4'd0, 32'h00001234);
        step();
        check_eq("t5_halted", halted, 1);

        // Asynchronous reset while halted.
        drive(4'd3, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6_halted", halted, 0);
        check_eq("t6_cause", cause, 0);
        check_eq("t6_cycles", cyc_cnt, 0);
        check_eq("t6_instrs", ins_cnt, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(4'd0, 32'h00001234);
        step();
        check_eq("t6_slots_off", halted, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(4'($urandom_range(0, 3)), pool[$urandom_range(0, 3)]);
            if ($urandom_range(0, 19) == 0) begin
                wr_en = 1'b1;
                wr_idx = 2'($urandom_range(0, NB - 1));
                wr_value = pool[$urandom_range(0, 3)];
                wr_mask = ($urandom_range(0, 1) != 0) ? 32'hffffffff : 32'hfc000000;
                wr_target = 8'($urandom_range(0, 3));
            end else begin
                wr_en = 1'b0;
            end
            resume = ($urandom_range(0, 4) == 0);
            step();
        end
        wr_en = 1'b0;
        resume = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
